sync_packet_gen: RTL

Transmit-side counterpart of the inbound sync detector. Builds 802.1Q-tagged Ethernet sync frames (VLAN ID 0xABC by default) and drives them onto a 512-bit AXI-stream master in the 250 MHz user-logic box. Frames launch either periodically from an internal timer or on an external trigger pulse. Each frame carries a sequence number and an optional timestamp.

---
 rtl/sync_packet_gen_if.sv | 14 +
 rtl/sync_packet_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sync_packet_gen_if.sv
// sync_packet_gen_if: 512-bit AXI-stream link carrying generated sync frames.
//   tvalid/tdata/tkeep/tlast/tuser : driven by the master (generator)
//   tready                         : driven by the slave (downstream sink)
interface sync_packet_gen_if;
    logic         tvalid;
    logic [511:0] tdata;
    logic [63:0]  tkeep;
    logic         tlast;
    logic [15:0]  tuser;
    logic         tready;

    modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/sync_packet_gen.sv
// sync_packet_gen: builds 802.1Q-tagged sync frames and streams them out on a
// 512-bit AXI-stream master. Frames launch from an internal period timer or a
// trigger pulse; each frame carries a sequence number and optional timestamp.
// Ports:
//   aclk, areset   clock, synchronous active-high reset
//   enable_i       master enable for timer and trigger
//   period_i       timer period in cycles (0 disables periodic launch)
//   trigger_i      single-cycle launch request
//   m_axis         AXI-stream master (sync_packet_gen_if.master)
//   seq_o          frames fully sent
//   missed_o       saturating count of dropped requests
//   busy_o         frame in flight
// Build option: define SYNC_GEN_TIMESTAMP_EN to place a 64-bit cycle count in
// tdata[239:176] of beat 0; otherwise that field is zero.
module sync_packet_gen #(
    parameter logic [11:0] VLAN_ID     = 12'hABC,
    parameter logic [2:0]  PCP         = 3'd0,
    parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h000A_3500_0001,
    parameter logic [15:0] INNER_ETYPE = 16'h88B5,
    parameter int unsigned PKT_BEATS   = 2
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 enable_i,
    input  logic [31:0]          period_i,
    input  logic                 trigger_i,
    sync_packet_gen_if.master    m_axis,
    output logic [31:0]          seq_o,
    output logic [15:0]          missed_o,
    output logic                 busy_o
);
    localparam int unsigned DATA_W = 512;
    localparam int unsigned KEEP_W = 64;
    localparam int unsigned BEAT_W = 2;
    localparam int unsigned TS_W   = 64;
    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(PKT_BEATS - 1);
    localparam logic [15:0]       FRAME_BYTES = 16'(64 * PKT_BEATS);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [31:0]         timer_q, timer_d;
    logic                req_tick, req, go, launch, hs, last_hs;
    logic                pending_q, pending_d;
    logic [31:0]         seq_q, seq_d;
    logic [15:0]         missed_q, missed_d;
    logic                tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [DATA_W-1:0]   tdata_q, tdata_d;
    logic [KEEP_W-1:0]   tkeep_q, tkeep_d;
    logic [15:0]         tuser_q, tuser_d;
    logic [TS_W-1:0]     ts_snap;

`ifdef SYNC_GEN_TIMESTAMP_EN
    // Free-running cycle counter, sampled at launch.
    logic [TS_W-1:0] ts_q;
    always_ff @(posedge aclk) begin
        if (areset) ts_q <= '0;
        else        ts_q <= ts_q + TS_W'(1);
    end
    assign ts_snap = ts_q;
`else
    assign ts_snap = '0;
`endif

    // Header beat; field slices match the receive-side detector.
    function automatic logic [DATA_W-1:0] build_beat0(input logic [31:0] seq,
                                                      input logic [TS_W-1:0] ts);
        logic [DATA_W-1:0] d;
        d            = '0;
        d[47:0]      = DST_MAC;
        d[95:48]     = SRC_MAC;
        d[111:96]    = 16'h8100;
        d[115:112]   = {PCP, 1'b0};
        d[127:116]   = VLAN_ID;
        d[143:128]   = INNER_ETYPE;
        d[175:144]   = seq;
        d[239:176]   = ts;
        return d;
    endfunction

    // Period timer; >= guards against period_i shrinking below the count.
    always_comb begin
        timer_d  = '0;
        req_tick = 1'b0;
        if (enable_i && (period_i != 32'd0)) begin
            if (timer_q >= period_i - 32'd1) req_tick = 1'b1;
            else                             timer_d  = timer_q + 32'd1;
        end
    end

    assign req     = enable_i & (trigger_i | req_tick);
    // Pending is ignored in the cycle enable drops, before it is cleared.
    assign go      = (pending_q & enable_i) | req;
    assign hs      = tvalid_q & m_axis.tready;
    assign last_hs = hs & (beat_q == LAST_BEAT);

    // Next-state, frame sequencing and request bookkeeping.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        pending_d = pending_q;
        seq_d     = seq_q;
        missed_d  = missed_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        tdata_d   = tdata_q;
        tkeep_d   = tkeep_q;
        tuser_d   = tuser_q;
        launch    = 1'b0;

        case (state_q)
            IDLE: begin
                if (go) launch = 1'b1;
            end
            SEND: begin
                if (last_hs) begin
                    seq_d = seq_q + 32'd1;
                    if (go) begin
                        launch = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tdata_d  = '0;
                    end
                end else if (hs) begin
                    beat_d  = beat_q + BEAT_W'(1);
                    tlast_d = (beat_d == LAST_BEAT);
                    tdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Launch snapshots seq_d so a back-to-back frame carries the new count.
        if (launch) begin
            state_d  = SEND;
            beat_d   = '0;
            tvalid_d = 1'b1;
            tlast_d  = (LAST_BEAT == '0);
            tdata_d  = build_beat0(seq_d, ts_snap);
            tkeep_d  = '1;
            tuser_d  = FRAME_BYTES;
        end

        if (!enable_i) begin
            pending_d = 1'b0;
        end else if (launch) begin
            pending_d = pending_q & req;
        end else if (req) begin
            if (!pending_q)                  pending_d = 1'b1;
            else if (missed_q != 16'hFFFF)   missed_d  = missed_q + 16'd1;
        end
    end

    // State and output registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            timer_q   <= '0;
            pending_q <= 1'b0;
            seq_q     <= '0;
            missed_q  <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tdata_q   <= '0;
            tkeep_q   <= '0;
            tuser_q   <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            seq_q     <= seq_d;
            missed_q  <= missed_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tdata_q   <= tdata_d;
            tkeep_q   <= tkeep_d;
            tuser_q   <= tuser_d;
        end
    end

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = tkeep_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tuser  = tuser_q;
    assign seq_o         = seq_q;
    assign missed_o      = missed_q;
    assign busy_o        = (state_q == SEND);
endmodule
